// File: rtl/pipo_arbiter.sv
// Round-robin arbiter sequencing single-writer loads into a shared PIPO holding register.
// Each load runs IDLE -> GRANT -> ACK; q is written only on the GRANT->ACK edge.
module pipo_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   din,
  input  logic                       lock,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qb,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] sel;
  logic            found;
  int unsigned     idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Search starts just past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDXW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= IDXW'(NUM_REQ - 1);
      win   <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (!lock && found) begin
            win   <= sel;
            gnt   <= onehot(sel);
            state <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (req[win]) begin
            q     <= din[int'(win)*WIDTH +: WIDTH];
            owner <= win;
            ptr   <= win;
            ack   <= onehot(win);
            state <= ACK;
          end else begin
            state <= IDLE;
          end
        end
        ACK: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign qb   = ~q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pipo_arbiter.sv
// Directed bench for pipo_arbiter (NUM_REQ=4, WIDTH=4) with hand-computed expectations.
module tb_pipo_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] din;
  logic        lock;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic [3:0]  qb;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pipo_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .lock(lock),
    .gnt(gnt), .ack(ack), .q(q), .qb(qb), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; din = 16'h4321; lock = 1'b0;
    tick(); tick();
    total++; if (q !== 4'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", q); end
    total++; if (qb !== 4'hF) begin bad++; $display("FAIL reset_qb got=%h exp=f", qb); end
    total++; if ({gnt, ack, busy, owner} !== 11'b0) begin
      bad++; $display("FAIL reset_ctl gnt=%b ack=%b busy=%b owner=%0d exp all zero", gnt, ack, busy, owner);
    end
    reset = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    req = 4'b0000;  // withdraw: no load, pointer stays at 3
    tick();
    total++; if ({gnt, ack, busy, q} !== 13'b0) begin
      bad++; $display("FAIL reset_withdraw gnt=%b ack=%b busy=%b q=%h exp zeros", gnt, ack, busy, q);
    end
  endtask

  task automatic test_single();
    req = 4'b0100; din = 16'h0A00;
    tick();
    total++; if ({gnt, ack, busy} !== {4'b0100, 4'b0000, 1'b1}) begin
      bad++; $display("FAIL single_gnt gnt=%b ack=%b busy=%b exp gnt=0100 ack=0000 busy=1", gnt, ack, busy);
    end
    tick();
    total++; if ({q, qb} !== 8'hA5) begin bad++; $display("FAIL single_q q=%h qb=%h exp a/5", q, qb); end
    total++; if ({gnt, ack, owner} !== {4'b0000, 4'b0100, 2'd2}) begin
      bad++; $display("FAIL single_ack gnt=%b ack=%b owner=%0d exp 0000/0100/2", gnt, ack, owner);
    end
    req = 4'b0000; din = 16'h0000;
    tick();
    total++; if ({ack, busy} !== 5'b0) begin bad++; $display("FAIL single_ackdrop ack=%b busy=%b exp 0", ack, busy); end
    tick(); tick();
    total++; if (q !== 4'hA) begin bad++; $display("FAIL single_hold q=%h exp=a", q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    reset = 1'b0; req = 4'b0000;
    tick();
    reset = 1'b1; req = 4'b1111; din = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      tick();
      total++; if ({gnt, ack} !== {exp_oh, 4'b0000}) begin
        bad++; $display("FAIL rr_gnt[%0d] gnt=%b ack=%b exp gnt=%b", i, gnt, ack, exp_oh);
      end
      tick();
      total++; if ({gnt, ack, q} !== {4'b0000, exp_oh, 4'((i % 4) + 1)}) begin
        bad++; $display("FAIL rr_ack[%0d] gnt=%b ack=%b q=%h exp ack=%b q=%0d", i, gnt, ack, q, exp_oh, (i % 4) + 1);
      end
      tick();
      total++; if ({gnt, ack, busy} !== 9'b0) begin
        bad++; $display("FAIL rr_idle[%0d] gnt=%b ack=%b busy=%b exp 0", i, gnt, ack, busy);
      end
    end
    req = 4'b0000;
  endtask

  // Pointer is 0 after the rotation; q=1, owner=0.
  task automatic test_withdraw();
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_gnt got=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
    total++; if ({gnt, ack, busy, q, owner} !== {9'b0, 4'h1, 2'd0}) begin
      bad++; $display("FAIL wd_noload gnt=%b ack=%b busy=%b q=%h owner=%0d exp 0/0/0/1/0", gnt, ack, busy, q, owner);
    end
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_ptr gnt=%b exp=0010", gnt); end
    tick();
    total++; if ({ack, q, owner} !== {4'b0010, 4'h2, 2'd1}) begin
      bad++; $display("FAIL wd_load ack=%b q=%h owner=%0d exp 0010/2/1", ack, q, owner);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_lock();
    int lbad;
    lbad = 0;
    lock = 1'b1; req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({gnt, busy} !== 5'b0) lbad++;
    end
    total++; if (lbad != 0) begin bad++; $display("FAIL lock_hold cycles_bad=%0d exp=0", lbad); end
    lock = 1'b0;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL lock_release gnt=%b exp=1000", gnt); end
    lock = 1'b1;
    tick();
    total++; if ({ack, q, owner} !== {4'b1000, 4'h4, 2'd3}) begin
      bad++; $display("FAIL lock_midgrant ack=%b q=%h owner=%0d exp 1000/4/3", ack, q, owner);
    end
    tick(); tick();
    total++; if ({gnt, busy} !== 5'b0) begin bad++; $display("FAIL lock_relock gnt=%b busy=%b exp 0", gnt, busy); end
    lock = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    int abad;
    abad = 0;
    req = 4'b0001; din = 16'h432C;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rm_gnt got=%b exp=0001", gnt); end
    reset = 1'b0;
    tick();
    total++; if ({gnt, ack, busy, q, qb} !== {9'b0, 4'h0, 4'hF}) begin
      bad++; $display("FAIL rm_reset gnt=%b ack=%b busy=%b q=%h qb=%h exp 0/0/0/0/f", gnt, ack, busy, q, qb);
    end
    reset = 1'b1; req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack !== 4'b0 || q !== 4'h0) abad++;
    end
    total++; if (abad != 0) begin bad++; $display("FAIL rm_noack cycles_bad=%0d exp=0", abad); end
  endtask

  initial begin
    reset = 1'b0; req = '0; din = '0; lock = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
